// File: rtl/gf180mcu_osu_sc_gp9t3v3__muxn_reg.sv
// Registered CHANNELS-input, WIDTH-bit multiplexer with a loadable select
// register, round-robin auto-advance with a wrap pulse, and an enabled output register.
module gf180mcu_osu_sc_gp9t3v3__muxn_reg #(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [SELW-1:0]           Sel,
  input  logic                      LD,
  input  logic                      AUTO,
  input  logic                      EN,
  output logic [WIDTH-1:0]          Y,
  output logic [SELW-1:0]           SelQ,
  output logic                      WRAP
);

  // One extra bit so CHANNELS itself is representable when it is a power of two.
  localparam logic [SELW:0]   CH_EXT = CHANNELS[SELW:0];
  localparam logic [SELW-1:0] LAST   = SELW'(CHANNELS - 1);
  localparam logic [SELW-1:0] ONE    = SELW'(1);

  logic [SELW-1:0]  r_sel;
  logic [WIDTH-1:0] r_y;
  logic             r_wrap;

  logic             w_ld_ok;
  logic             w_last;
  logic [SELW-1:0]  w_sel_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_y_mux;

  assign w_ld_ok = ({1'b0, Sel} < CH_EXT);
  assign w_last  = (r_sel == LAST);

  // Channel decode: compare against each legal index rather than a
  // variable part-select, so out-of-range S can never address past D.
  always_comb begin
    w_y_mux = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_sel == SELW'(k)) begin
        w_y_mux = D[k*WIDTH +: WIDTH];
      end
    end
  end

  // An out-of-range load still consumes the cycle: S holds and AUTO is skipped.
  always_comb begin
    w_sel_nxt  = r_sel;
    w_wrap_nxt = 1'b0;
    if (LD) begin
      if (w_ld_ok) begin
        w_sel_nxt = Sel;
      end
    end else if (AUTO && EN) begin
      if (w_last) begin
        w_sel_nxt  = '0;
        w_wrap_nxt = 1'b1;
      end else begin
        w_sel_nxt  = r_sel + ONE;
      end
    end
  end

  // Register stage: Y captures the channel chosen by the pre-update S.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sel  <= '0;
      r_y    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_sel  <= w_sel_nxt;
      r_wrap <= w_wrap_nxt;
      if (EN) begin
        r_y <= w_y_mux;
      end
    end
  end

  assign Y    = r_y;
  assign SelQ = r_sel;
  assign WRAP = r_wrap;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__muxn_reg.sv
// Bench for the registered N-channel mux: three instances (4, 3 and 1 channels)
// share stimulus and are compared every cycle against a channel-count-generic model.
module tb_gf180mcu_osu_sc_gp9t3v3__muxn_reg;

  logic        CLK = 1'b0;
  logic        rst, ld, auto, en;
  logic [1:0]  sel;
  logic [31:0] d;

  logic [7:0]  y4, y3, y1;
  logic [1:0]  q4, q3;
  logic [0:0]  q1;
  logic        w4, w3, w1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state per instance: index 0 -> 4 ch, 1 -> 3 ch, 2 -> 1 ch.
  int          m_chan [3] = '{4, 3, 1};
  int          m_selm [3] = '{3, 3, 1};
  int          m_s    [3];
  logic [7:0]  m_y    [3];
  logic        m_w    [3];

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_gp9t3v3__muxn_reg #(.WIDTH(8), .CHANNELS(4)) u4 (
    .CLK(CLK), .RST(rst), .D(d), .Sel(sel), .LD(ld), .AUTO(auto), .EN(en),
    .Y(y4), .SelQ(q4), .WRAP(w4));

  gf180mcu_osu_sc_gp9t3v3__muxn_reg #(.WIDTH(8), .CHANNELS(3)) u3 (
    .CLK(CLK), .RST(rst), .D(d[23:0]), .Sel(sel), .LD(ld), .AUTO(auto), .EN(en),
    .Y(y3), .SelQ(q3), .WRAP(w3));

  gf180mcu_osu_sc_gp9t3v3__muxn_reg #(.WIDTH(8), .CHANNELS(1)) u1 (
    .CLK(CLK), .RST(rst), .D(d[7:0]), .Sel(sel[0:0]), .LD(ld), .AUTO(auto), .EN(en),
    .Y(y1), .SelQ(q1), .WRAP(w1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural rule applied to one instance for one clock edge.
  task automatic model_edge(input int i);
    int s_in;
    s_in = int'(sel) & m_selm[i];
    if (rst) begin
      m_s[i] = 0; m_y[i] = 8'h00; m_w[i] = 1'b0;
    end else begin
      if (en) m_y[i] = 8'((d >> (m_s[i] * 8)) & 32'hFF);
      m_w[i] = 1'b0;
      if (ld) begin
        if (s_in < m_chan[i]) m_s[i] = s_in;
      end else if (auto && en) begin
        m_w[i] = (m_s[i] == m_chan[i] - 1);
        m_s[i] = (m_s[i] + 1) % m_chan[i];
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [1:0] s,
                      input logic a, input logic e);
    rst = r; ld = l; sel = s; auto = a; en = e;
    @(posedge CLK);
    for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    chk("y4",    32'(y4), 32'(m_y[0]));
    chk("selq4", 32'(q4), 32'(m_s[0]));
    chk("wrap4", 32'(w4), 32'(m_w[0]));
    chk("y3",    32'(y3), 32'(m_y[1]));
    chk("selq3", 32'(q3), 32'(m_s[1]));
    chk("wrap3", 32'(w3), 32'(m_w[1]));
    chk("y1",    32'(y1), 32'(m_y[2]));
    chk("selq1", 32'(q1), 32'(m_s[2]));
    chk("wrap1", 32'(w1), 32'(m_w[2]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ld = 1'b0; sel = 2'd0; auto = 1'b0; en = 1'b0;
    d = 32'hDDCC_BBAA;
    for (int i = 0; i < 3; i++) begin m_s[i] = 0; m_y[i] = 8'h00; m_w[i] = 1'b0; end

    // Reset with EN high, then first enabled edge picks channel 0.
    step(1, 0, 0, 0, 1);
    chk("rst_y",    32'(y4), 32'h00);
    chk("rst_selq", 32'(q4), 32'h0);
    chk("rst_wrap", 32'(w4), 32'h0);
    step(0, 0, 0, 0, 1);
    chk("post_rst_y", 32'(y4), 32'hAA);

    // Load latency: SelQ one edge later, Y two edges later.
    step(0, 1, 2, 0, 1);
    chk("ld_selq", 32'(q4), 32'h2);
    step(0, 0, 0, 0, 1);
    chk("ld_y", 32'(y4), 32'hCC);

    // Auto scan from S=0 with wrap.
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1); chk("scan_y0", 32'(y4), 32'hAA);
    step(0, 0, 0, 1, 1); chk("scan_y1", 32'(y4), 32'hBB);
    step(0, 0, 0, 1, 1); chk("scan_y2", 32'(y4), 32'hCC);
    step(0, 0, 0, 1, 1); chk("scan_y3", 32'(y4), 32'hDD);
    chk("scan_wrap", 32'(w4), 32'h1);
    chk("scan_sel0", 32'(q4), 32'h0);
    step(0, 0, 0, 1, 1); chk("scan_y4", 32'(y4), 32'hAA);
    chk("scan_nowrap", 32'(w4), 32'h0);

    // Priority: LD beats AUTO at S=3, then EN=0 freezes everything.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("pri_s3", 32'(q4), 32'h3);
    step(0, 1, 1, 1, 1);
    chk("pri_selq", 32'(q4), 32'h1);
    chk("pri_wrap", 32'(w4), 32'h0);
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      step(0, 0, 0, 1, 0);
      chk("frz_selq", 32'(q4), 32'h1);
      chk("frz_y",    32'(y4), 32'hDD);
    end
    d = 32'hDDCC_BBAA;

    // Three-channel guard: Sel=3 ignored and no AUTO step; wrap from 2.
    step(1, 0, 0, 0, 1);
    step(0, 1, 3, 1, 1);
    chk("g3_hold", 32'(q3), 32'h0);
    step(0, 1, 2, 0, 1);
    step(0, 0, 0, 1, 1);
    chk("g3_sel0", 32'(q3), 32'h0);
    chk("g3_wrap", 32'(w3), 32'h1);

    // Reset mid-scan at S=2, scan resumes from channel 0 without WRAP.
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("mid_s2", 32'(q4), 32'h2);
    step(1, 0, 0, 1, 1);
    chk("mid_rst_s", 32'(q4), 32'h0);
    chk("mid_rst_y", 32'(y4), 32'h00);
    step(0, 0, 0, 1, 1);
    chk("mid_res_y", 32'(y4), 32'hAA);
    chk("mid_res_s", 32'(q4), 32'h1);
    chk("mid_res_w", 32'(w4), 32'h0);

    // Single-channel instance: continuous wrap under AUTO=EN=1.
    step(0, 0, 0, 1, 1);
    chk("c1_wrap", 32'(w1), 32'h1);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      d = $urandom;
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_gp9t3v3__muxn_reg.md
# gf180mcu_osu_sc_gp9t3v3__muxn_reg

Parametrised, registered N-channel, WIDTH-bit multiplexer for the 9-track 3.3 V library. It generalises the two-input combinational mux to CHANNELS inputs. It adds a select register with explicit load, a round-robin auto-advance mode with a wrap pulse, and an enabled output register. It serves as a synthesis-friendly macro for data-path steering, TDM channel scanning and muxed-bus capture in the gp9t3v3 flow.

## Interface
Parameters:
- WIDTH, 1, bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥1; need not be a power of two)
- SELW (localparam), max(1, clog2(CHANNELS)), select width

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous active-high reset
- D  input  CHANNELS*WIDTH  channel data; channel k is D[k*WIDTH +: WIDTH]
- Sel  input  SELW  channel index to load
- LD  input  1  load Sel into select register
- AUTO  input  1  round-robin advance mode
- EN  input  1  output-register / advance enable
- Y  output  WIDTH  registered selected data
- SelQ  output  SELW  current select register value S
- WRAP  output  1  one-cycle pulse: auto-advance wrapped CHANNELS-1 → 0

## Operation
- State:
  - select register S (SELW bits)
  - output register Y
  - WRAP flop
- Reset: when RST=1 at a rising edge, S=0, Y=0 and WRAP=0. RST overrides LD, AUTO and EN.
- Select-register update, priority order, evaluated per edge:
  - If LD=1 and Sel<CHANNELS, then S ← Sel.
  - If LD=1 and Sel≥CHANNELS, then S holds. The load is ignored and AUTO is not applied that cycle.
  - Else, if AUTO=1 and EN=1: S ← (S==CHANNELS-1) ? 0 : S+1.
  - Otherwise S holds.
- EN gates auto-advance. LD is honoured regardless of EN.
- Output register:
  - If EN=1, Y ← D[S_old*WIDTH +: WIDTH], using the S value before the same-edge update.
  - If EN=0, Y holds.
- WRAP ← 1 exactly on an edge where auto-advance takes S from CHANNELS-1 to 0. Otherwise WRAP ← 0. An LD to 0 never sets WRAP.
- SelQ = S, a direct register output.
- CHANNELS=1:
  - S is always 0.
  - Every auto-advance edge is a wrap, so with AUTO=EN=1, WRAP stays 1 continuously.
- Non-power-of-two CHANNELS: S never takes values ≥CHANNELS. Reset and the load guard together guarantee this.
- Equivalence: with CHANNELS=2, WIDTH=1, LD=1, AUTO=0, EN=1, Y equals the two-input mux function (Sel ? D[1] : D[0]), delayed two cycles from Sel.

## Timing
- Data latency:
  - D → Y: 1 cycle, D sampled at edge n, visible after edge n.
  - Sel/LD → SelQ: 1 cycle.
  - Sel/LD → Y reflecting the new channel: 2 cycles.
- Auto mode with EN held high: Y after edge n carries the channel selected by S during cycle n. The channel sequence is 0,1,…,CHANNELS-1,0,…
- WRAP is high for the single cycle following the wrapping edge. It is coincident with SelQ=0.
- Simultaneous events:
  - LD with AUTO: LD wins.
  - RST with anything: reset wins.
  - EN=0 with AUTO: S and Y both freeze.
- Reset mid-operation: the next cycle shows S=0, Y=0, WRAP=0. An auto sequence restarts at channel 0 after RST deasserts.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: WIDTH=8, CHANNELS=4, pulse RST with D=0xDD_CC_BB_AA and EN=1 → Y=0x00, SelQ=0, WRAP=0 the cycle after; the next edge with EN=1 gives Y=0xAA.
- Load/latency: LD=1, Sel=2 at edge 0, EN=1 → SelQ=2 after edge 0, Y=0xCC after edge 1.
- Auto scan and wrap: AUTO=1, EN=1 from S=0, CHANNELS=4 → Y sequence 0xAA,0xBB,0xCC,0xDD,0xAA. WRAP=1 only in the cycle where SelQ returns to 0.
- Non-power-of-two and guard: CHANNELS=3, LD=1, Sel=3 → SelQ unchanged and no AUTO step. Auto from S=2 → S=0 with WRAP=1.
- Priority/enable: AUTO=1, EN=1, LD=1, Sel=1 at S=3 → SelQ=1, WRAP=0. Then EN=0 for 3 cycles → SelQ and Y frozen.
- RST mid-scan: during AUTO with S=2, assert RST one cycle → S=0, Y=0. On release, the scan resumes at channel 0 with no WRAP pulse.
